// File: rtl/counter_step_scheduler.sv
// ---------------------------------------------------------------------------
// counter_step_scheduler
//   Round-robin arbiter that shares one dual-stride up/down counter among
//   NREQ requesters. Each grant is bound-checked against a shadow copy of the
//   counter value, then drives at most one counter enable for one cycle.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   req       in   [NREQ]     per-requester request, held until ack or err
//   op        in   [2*NREQ]   op[2i+1:2i]: 00 INC1, 01 INC2, 10 DEC, 11 reserved
//   ack       out  [NREQ]     one-cycle pulse, op accepted and issued
//   err       out  [NREQ]     one-cycle pulse, op rejected (bound or reserved)
//   en1       out             counter +1 enable pulse
//   en2       out             counter +2 enable pulse
//   en_d      out             counter -1 enable pulse
//   count     out  [WIDTH]    shadow count, tracks the counter after each issue
//   grant_id  out  [log2 NREQ] requester in service (valid while busy)
//   busy      out             high in GRANT and ISSUE
// ---------------------------------------------------------------------------
module counter_step_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int MAXV  = 2**WIDTH - 1,
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   err,
    output logic              en1,
    output logic              en2,
    output logic              en_d,
    output logic [WIDTH-1:0]  count,
    output logic [GW-1:0]     grant_id,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    localparam logic [1:0] OP_INC1 = 2'b00;
    localparam logic [1:0] OP_INC2 = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;

    localparam logic [WIDTH:0] MAXV_X = (WIDTH+1)'(MAXV);

    logic [1:0]       state;
    logic [GW-1:0]    rr_ptr;
    logic [1:0]       op_q;
    logic             legal_q;

    logic             sel_found;
    logic [GW-1:0]    sel_id;
    logic [1:0]       sel_op;
    logic             sel_legal;
    logic [WIDTH:0]   count_x;
    logic [NREQ-1:0]  gid_oh;
    logic             others;
    logic             issue;

    // First requester at or after the RR pointer, with wrap.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_id    = '0;
        sel_op    = 2'b00;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_id    = GW'(idx);
                sel_op    = op[2*idx +: 2];
            end
        end
    end

    // Bound check done one bit wider so count+2 cannot wrap past MAXV.
    assign count_x = {1'b0, count};
    always_comb begin
        sel_legal = 1'b0;
        case (sel_op)
            OP_INC1: sel_legal = (count_x + 1'b1)      <= MAXV_X;
            OP_INC2: sel_legal = (count_x + (WIDTH+1)'(2)) <= MAXV_X;
            OP_DEC:  sel_legal = (count != '0);
            default: sel_legal = 1'b0;
        endcase
    end

    assign gid_oh = NREQ'(1) << grant_id;
    assign others = |(req & ~gid_oh);
    assign issue  = (state == S_ISSUE);

    // Responses decode straight from state so an async reset kills them at once.
    assign en1  = issue & legal_q & (op_q == OP_INC1);
    assign en2  = issue & legal_q & (op_q == OP_INC2);
    assign en_d = issue & legal_q & (op_q == OP_DEC);
    assign ack  = (issue &  legal_q) ? gid_oh : '0;
    assign err  = (issue & ~legal_q) ? gid_oh : '0;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            op_q     <= 2'b00;
            legal_q  <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) state <= S_GRANT;
                end
                S_GRANT: begin
                    // A request dropped before this edge is simply withdrawn.
                    if (sel_found) begin
                        grant_id <= sel_id;
                        op_q     <= sel_op;
                        legal_q  <= sel_legal;
                        state    <= S_ISSUE;
                    end else begin
                        state    <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (legal_q) begin
                        case (op_q)
                            OP_INC1: count <= count + 1'b1;
                            OP_INC2: count <= count + WIDTH'(2);
                            OP_DEC:  count <= count - 1'b1;
                            default: count <= count;
                        endcase
                    end
                    rr_ptr <= (grant_id == GW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                    state  <= others ? S_GRANT : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_step_scheduler.sv
module tb_counter_step_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int MAXV  = 15;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op;
    logic [NREQ-1:0]   ack, err;
    logic              en1, en2, en_d;
    logic [WIDTH-1:0]  count;
    logic [1:0]        grant_id;
    logic              busy;

    counter_step_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXV(MAXV)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .ack(ack), .err(err),
        .en1(en1), .en2(en2), .en_d(en_d), .count(count),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0]  ack;
        logic [NREQ-1:0]  err;
        logic [2:0]       en;    // {en1,en2,en_d}
        logic [WIDTH-1:0] cnt;   // count visible during the response cycle
    } resp_t;

    resp_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    mc      = 0;          // bench model of the counter
    int    last_lat;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any response must match the head of the scoreboard.
    always @(negedge clk) begin
        resp_t act, e;
        if (rst) begin
            n_tests++;
            if (int'(en1) + int'(en2) + int'(en_d) > 1 || !$onehot0(ack | err)) begin
                n_fail++;
                $display("FAIL mutex: en=%b%b%b ack=%b err=%b", en1, en2, en_d, ack, err);
            end
            if ((ack | err) != '0) begin
                act = '{ack: ack, err: err, en: {en1, en2, en_d}, cnt: count};
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp: got %h, required none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL resp: got ack=%b err=%b en=%b cnt=%0d, required ack=%b err=%b en=%b cnt=%0d",
                                 act.ack, act.err, act.en, act.cnt, e.ack, e.err, e.en, e.cnt);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    function automatic logic [2:0] en_of(input logic [1:0] o);
        case (o)
            2'b00:   return 3'b100;
            2'b01:   return 3'b010;
            2'b10:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit model_legal(input logic [1:0] o);
        case (o)
            2'b00:   return mc + 1 <= MAXV;
            2'b01:   return mc + 2 <= MAXV;
            2'b10:   return mc > 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_exp(input int id, input logic [1:0] o, input bit legal);
        resp_t e;
        e.ack = legal ? NREQ'(1) << id : '0;
        e.err = legal ? '0 : NREQ'(1) << id;
        e.en  = legal ? en_of(o) : 3'b000;
        e.cnt = WIDTH'(mc);
        exp_q.push_back(e);
        if (legal) mc += (o == 2'b00) ? 1 : (o == 2'b01) ? 2 : -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        op  = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mc  = 0;
        exp_q.delete();
    endtask

    // Single requester op; returns after its response (or a bounded timeout).
    task automatic run_op(input int id, input logic [1:0] o, input bit legal);
        int n;
        @(negedge clk);
        push_exp(id, o, legal);
        op[2*id +: 2] = o;
        req[id]       = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack[id] | err[id]) && n < 20);
        last_lat = n;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL timeout: req %0d op %b got no response, required one", id, o);
        end
        req[id] = 1'b0;
    endtask

    initial begin
        int t_prev, n;
        logic [1:0] o;
        int id;
        rst = 1'b0;
        req = '0;
        op  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",  busy, 0);
        check("reset_count", count, 0);
        check("reset_out",   {ack, err, en1, en2, en_d}, 0);
        check("reset_gid",   grant_id, 0);
        rst = 1'b1;

        // 1: single INC2, response two edges after req
        run_op(0, 2'b01, 1'b1);
        check("t1_latency", last_lat, 2);
        @(negedge clk);
        check("t1_count", count, 2);

        // 2: all four hold INC1 -> order 0,1,2,3,0 one per two cycles
        do_reset();
        for (int k = 0; k < 5; k++) push_exp(k % NREQ, 2'b00, 1'b1);
        op  = '0;
        req = 4'b1111;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ack == '0 && n < 20);
            if (n >= 20) begin
                n_fail++;
                $display("FAIL t2_timeout: ack %0d missing, required present", k);
            end
            if (k > 0) check("t2_spacing", cyc - t_prev, 2);
            t_prev = cyc;
        end
        req = '0;
        repeat (3) @(negedge clk);
        check("t2_count", count, 5);

        // 3: upper bound
        for (int k = 0; k < 9; k++) run_op(0, 2'b00, 1'b1);
        @(negedge clk);
        check("t3_count14", count, 14);
        run_op(0, 2'b01, 1'b0);          // 14+2 > 15
        run_op(0, 2'b00, 1'b1);          // 15
        run_op(1, 2'b00, 1'b0);          // already at MAXV
        run_op(3, 2'b01, 1'b0);
        @(negedge clk);
        check("t3_count15", count, 15);

        // 4: lower bound and reserved op
        do_reset();
        run_op(2, 2'b10, 1'b0);
        run_op(3, 2'b11, 1'b0);
        run_op(1, 2'b00, 1'b1);
        run_op(2, 2'b10, 1'b1);
        run_op(2, 2'b10, 1'b0);
        @(negedge clk);
        check("t4_count0", count, 0);

        // 5: reset in the middle of ISSUE, op discarded
        run_op(0, 2'b01, 1'b1);          // count 2
        @(negedge clk);
        op[3:2] = 2'b00;
        req[1]  = 1'b1;
        @(posedge clk);                  // -> GRANT
        @(posedge clk);                  // -> ISSUE
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_en",  {en1, en2, en_d}, 0);
        check("t5_async_ack", {ack, err}, 0);
        check("t5_async_cnt", count, 0);
        check("t5_async_busy", busy, 0);
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        mc  = 0;
        repeat (6) @(negedge clk);
        check("t5_count_after", count, 0);
        check("t5_no_pending", exp_q.size(), 0);

        // 6: random single-requester ops against the model counter
        for (int k = 0; k < 300; k++) begin
            id = $urandom_range(NREQ-1);
            o  = 2'($urandom_range(3));
            run_op(id, o, model_legal(o));
        end
        @(negedge clk);
        check("t6_count_model", count, mc);
        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
